// File: rtl/ds18b20_pkg.sv
// Shared timing constants, 1-Wire command bytes and FSM states for the
// multi-channel DS18B20 reader.
package ds18b20_pkg;

  localparam int T_RST    = 480;
  localparam int T_PRES   = 70;
  localparam int T_SLOT   = 70;
  localparam int T_W0     = 60;
  localparam int T_W1     = 6;
  localparam int T_RD_LOW = 6;
  localparam int T_RD_SMP = 15;

  localparam logic [7:0] CMD_SKIP = 8'hCC;
  localparam logic [7:0] CMD_CONV = 8'h44;
  localparam logic [7:0] CMD_READ = 8'hBE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_PRES,
    ST_TX,
    ST_CONV_WAIT,
    ST_RX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/onewire_crc8.sv
// Bit-serial Dallas/Maxim CRC8 (x^8+x^5+x^4+1, reflected 0x8C), LSB first.
module onewire_crc8 (
  input  logic       local_clk,
  input  logic       local_rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[0] ^ bit_in;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = (crc_q >> 1) ^ (fb ? 8'h8C : 8'h00);
    end
  end

  always_ff @(posedge local_clk) begin
    if (local_rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ds18b20_multi_reader.sv
// N-channel DS18B20 reader: one shared 1-Wire timing FSM drives every bus in
// lockstep while each channel keeps its own presence, CRC and temperature.
module ds18b20_multi_reader
  import ds18b20_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CLK_HZ  = 50_000_000,
  parameter int CONV_US = 750_000
) (
  input  logic                local_clk,
  input  logic                local_rst,
  input  logic                start,
  output logic                busy,
  output logic [N_CH-1:0]     bus_oe,
  input  logic [N_CH-1:0]     bus_in,
  output logic [N_CH-1:0]     present,
  output logic [N_CH-1:0]     crc_ok,
  output logic [16*N_CH-1:0]  temp,
  output logic                done
);

  localparam int US_DIV  = CLK_HZ / 1_000_000;
  localparam int DIV_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int CNT_MAX = (CONV_US > T_RST) ? CONV_US : T_RST;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                 state_q, state_d;
  logic                   phase_q, phase_d;
  logic                   byte_q, byte_d;
  logic [6:0]             bit_q, bit_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [CNT_W-1:0]       us_q, us_d;
  logic [N_CH-1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_CH-1:0]        pres_q, pres_d;
  logic [N_CH-1:0][15:0]  sr_q, sr_d;
  logic [N_CH-1:0]        present_q, present_d;
  logic [N_CH-1:0]        crc_ok_q, crc_ok_d;
  logic [N_CH-1:0][15:0]  temp_q, temp_d;
  logic                   oe_q, oe_d;
  logic                   crc_clr, crc_en;
  logic [7:0]             crc_w [N_CH];
  logic                   us_tick, slot_end;
  logic [7:0]             cmd_byte;

  assign us_tick = (div_q == DIV_W'(US_DIV - 1));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    div_d     = us_tick ? '0 : div_q + 1'b1;
    us_d      = us_tick ? us_q + 1'b1 : us_q;
    sync1_d   = bus_in;
    sync2_d   = sync1_q;
    pres_d    = pres_q;
    sr_d      = sr_q;
    present_d = present_q;
    crc_ok_d  = crc_ok_q;
    temp_d    = temp_q;
    oe_d      = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    slot_end  = us_tick && (us_q == CNT_W'(T_SLOT - 1));
    cmd_byte  = phase_q ? (byte_q ? CMD_READ : CMD_SKIP)
                        : (byte_q ? CMD_CONV : CMD_SKIP);

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        us_d  = '0;
        if (start) begin
          state_d = ST_RST_LOW;
          phase_d = 1'b0;
          byte_d  = 1'b0;
          bit_d   = '0;
        end
      end
      ST_RST_LOW: begin
        oe_d = 1'b1;
        if (us_tick && us_q == CNT_W'(T_RST - 1)) begin
          state_d = ST_RST_PRES;
          us_d    = '0;
        end
      end
      ST_RST_PRES: begin
        if (us_tick && us_q == CNT_W'(T_PRES - 1)) begin
          pres_d = ~sync2_q;
        end
        if (us_tick && us_q == CNT_W'(T_RST - 1)) begin
          state_d = ST_TX;
          us_d    = '0;
          byte_d  = 1'b0;
          bit_d   = '0;
        end
      end
      ST_TX: begin
        oe_d = us_q < (cmd_byte[bit_q[2:0]] ? CNT_W'(T_W1) : CNT_W'(T_W0));
        if (slot_end) begin
          us_d = '0;
          if (bit_q == 7'd7) begin
            bit_d = '0;
            if (!byte_q) begin
              byte_d = 1'b1;
            end else if (phase_q) begin
              state_d = ST_RX;
              crc_clr = 1'b1;
              sr_d    = '0;
            end else begin
              state_d = ST_CONV_WAIT;
            end
          end else begin
            bit_d = bit_q + 7'd1;
          end
        end
      end
      ST_CONV_WAIT: begin
        if (us_tick && us_q == CNT_W'(CONV_US - 1)) begin
          state_d = ST_RST_LOW;
          phase_d = 1'b1;
          us_d    = '0;
        end
      end
      ST_RX: begin
        oe_d = us_q < CNT_W'(T_RD_LOW);
        if (us_tick && us_q == CNT_W'(T_RD_SMP - 1)) begin
          crc_en = 1'b1;
          if (bit_q < 7'd16) begin
            for (int k = 0; k < N_CH; k++) begin
              sr_d[k] = {sync2_q[k], sr_q[k][15:1]};
            end
          end
        end
        if (slot_end) begin
          us_d = '0;
          if (bit_q == 7'd71) begin
            state_d = ST_DONE;
            // Results land on the same edge that enters DONE so they are valid with done.
            for (int k = 0; k < N_CH; k++) begin
              present_d[k] = pres_q[k];
              crc_ok_d[k]  = pres_q[k] && (crc_w[k] == 8'h00);
              if (pres_q[k] && (crc_w[k] == 8'h00)) begin
                temp_d[k] = sr_q[k];
              end
            end
          end else begin
            bit_d = bit_q + 7'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge local_clk) begin
    if (local_rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      byte_q    <= 1'b0;
      bit_q     <= '0;
      div_q     <= '0;
      us_q      <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      pres_q    <= '0;
      sr_q      <= '0;
      present_q <= '0;
      crc_ok_q  <= '0;
      temp_q    <= '0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      us_q      <= us_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pres_q    <= pres_d;
      sr_q      <= sr_d;
      present_q <= present_d;
      crc_ok_q  <= crc_ok_d;
      temp_q    <= temp_d;
      oe_q      <= oe_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    onewire_crc8 u_crc (
      .local_clk (local_clk),
      .local_rst (local_rst),
      .clr       (crc_clr),
      .en        (crc_en),
      .bit_in    (sync2_q[k]),
      .crc       (crc_w[k])
    );
    assign temp[16*k +: 16] = temp_q[k];
  end

  assign bus_oe  = {N_CH{oe_q}};
  assign present = present_q;
  assign crc_ok  = crc_ok_q;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_ds18b20_multi_reader.sv
// Directed bench for ds18b20_multi_reader: four behavioural DS18B20 models on
// separate buses plus a bus_oe pulse-width monitor on channel 0.
`timescale 1ns/1ps
module tb_ds18b20_multi_reader;

  localparam int N_CH        = 4;
  localparam int CLK_HZ      = 2_000_000;
  localparam int CONV_US     = 2_000;
  localparam int CLK_PERIOD  = 500;
  localparam int US          = 1000;
  localparam int CYCLE_LIMIT = 30_000;
  localparam logic [63:0] POR_DATA = 64'h10_0C_FF_7F_46_4B_05_50;

  logic        local_clk = 1'b0;
  logic        local_rst = 1'b1;
  logic        start     = 1'b0;
  logic        busy, done;
  logic [3:0]  bus_oe, bus_in, present, crc_ok;
  logic [63:0] temp;

  logic [3:0]  dev_present = 4'hF;
  logic [7:0]  scratch [4][9];
  logic [3:0]  conv_seen_w, read_seen_w;

  int  checks = 0;
  int  errors = 0;
  int  pulse_cnt = 0;
  int  done_cnt = 0;
  int  timing_bad = 0;
  time bad_width = 0;
  time mon_fall = 0;
  bit  mon_have = 1'b0;
  bit  mon_ignore = 1'b0;

  always #(CLK_PERIOD/2) local_clk = ~local_clk;

  ds18b20_multi_reader #(
    .N_CH    (N_CH),
    .CLK_HZ  (CLK_HZ),
    .CONV_US (CONV_US)
  ) dut (
    .local_clk (local_clk),
    .local_rst (local_rst),
    .start     (start),
    .busy      (busy),
    .bus_oe    (bus_oe),
    .bus_in    (bus_in),
    .present   (present),
    .crc_ok    (crc_ok),
    .temp      (temp),
    .done      (done)
  );

  // One DS18B20 per bus: presence after reset, decodes 16 command bits, answers read slots.
  for (genvar k = 0; k < 4; k++) begin : g_dev
    logic        pull = 1'b0;
    logic        conv_seen = 1'b0;
    logic        read_seen = 1'b0;
    int          slot_cnt = 0;
    int          rd_idx = 0;
    logic [15:0] cmd_sr = '0;
    logic        rd_zero = 1'b0;
    time         t_fall = 0;
    time         width = 0;

    assign bus_in[k]      = ~(bus_oe[k] | pull);
    assign conv_seen_w[k] = conv_seen;
    assign read_seen_w[k] = read_seen;

    always begin
      @(posedge bus_oe[k]);
      t_fall  = $time;
      rd_zero = 1'b0;
      if (dev_present[k] && cmd_sr == 16'hBECC && slot_cnt >= 16 && slot_cnt < 88) begin
        rd_idx  = slot_cnt - 16;
        rd_zero = ~scratch[k][rd_idx / 8][rd_idx % 8];
        if (rd_zero) pull = 1'b1;
      end
      @(negedge bus_oe[k]);
      width = $time - t_fall;
      if (width > 400 * US) begin
        slot_cnt = 0;
        cmd_sr   = '0;
        pull     = 1'b0;
        if (dev_present[k]) begin
          #(15 * US);
          pull = 1'b1;
          #(120 * US);
          pull = 1'b0;
        end
      end else begin
        if (slot_cnt < 16) cmd_sr = {(width < 30 * US), cmd_sr[15:1]};
        slot_cnt++;
        if (slot_cnt == 16 && dev_present[k] && cmd_sr == 16'h44CC) conv_seen = 1'b1;
        if (slot_cnt == 16 && dev_present[k] && cmd_sr == 16'hBECC) read_seen = 1'b1;
        if (rd_zero) begin
          #(t_fall + 30 * US - $time);
          pull = 1'b0;
        end
      end
    end
  end

  function automatic bit near_us(input time w, input int target);
    time t;
    t = target * US;
    return (w + US >= t) && (w <= t + US);
  endfunction

  always @(posedge bus_oe[0]) begin
    pulse_cnt++;
    if (mon_have && ($time - mon_fall) < 70 * US) begin
      timing_bad++;
      bad_width = $time - mon_fall;
    end
    mon_fall = $time;
    mon_have = 1'b1;
  end

  always @(negedge bus_oe[0]) begin
    if (mon_ignore) begin
      mon_ignore = 1'b0;
    end else if (mon_have) begin
      if (!(near_us($time - mon_fall, 480) || near_us($time - mon_fall, 60) ||
            near_us($time - mon_fall, 6))) begin
        timing_bad++;
        bad_width = $time - mon_fall;
      end
    end
  end

  always @(negedge local_clk) begin
    if (done === 1'b1) done_cnt++;
  end

  function automatic logic [7:0] dallas_crc(input logic [63:0] data);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? 8'h8C : 8'h00);
    end
    return c;
  endfunction

  task automatic set_scratch(input int k, input logic [63:0] data, input logic [7:0] crc);
    for (int b = 0; b < 8; b++) scratch[k][b] = data[8*b +: 8];
    scratch[k][8] = crc;
  endtask

  task automatic drive_start();
    @(negedge local_clk);
    start = 1'b1;
    @(negedge local_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    int n;
    n    = 0;
    seen = 1'b0;
    while (n < CYCLE_LIMIT && !seen) begin
      @(negedge local_clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    local_rst = 1'b1;
    repeat (5) @(negedge local_clk);
    checks++; if (bus_oe !== 4'h0) begin errors++; $display("[TB] FAIL reset bus_oe: got %h expected 0", bus_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    checks++; if (present !== 4'h0) begin errors++; $display("[TB] FAIL reset present: got %h expected 0", present); end
    checks++; if (crc_ok !== 4'h0) begin errors++; $display("[TB] FAIL reset crc_ok: got %h expected 0", crc_ok); end
    checks++; if (temp !== 64'h0) begin errors++; $display("[TB] FAIL reset temp: got %h expected 0", temp); end
    local_rst = 1'b0;
    repeat (3) @(negedge local_clk);
  endtask

  task automatic test_power_on_and_start();
    bit seen;
    int base_pulse, base_done;
    for (int k = 0; k < 4; k++) set_scratch(k, POR_DATA, 8'h1C);
    dev_present = 4'hF;
    base_pulse  = pulse_cnt;
    base_done   = done_cnt;
    drive_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start busy: got %b expected 1", busy); end
    repeat (2000) @(negedge local_clk);
    start = 1'b1;
    @(negedge local_clk);
    start = 1'b0;
    wait_done(seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL power_on done: got none expected pulse within %0d clocks", CYCLE_LIMIT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL power_on busy in done cycle: got %b expected 0", busy); end
    checks++; if (present !== 4'hF) begin errors++; $display("[TB] FAIL power_on present: got %h expected f", present); end
    checks++; if (crc_ok !== 4'hF) begin errors++; $display("[TB] FAIL power_on crc_ok: got %h expected f", crc_ok); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (temp[16*k +: 16] !== 16'h0550) begin
        errors++;
        $display("[TB] FAIL power_on temp ch%0d: got %h expected 0550", k, temp[16*k +: 16]);
      end
    end
    start = 1'b1;
    @(negedge local_clk);
    start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done width: got %b expected 0 one cycle later", done); end
    repeat (1200) @(negedge local_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL start_in_done busy: got %b expected 0", busy); end
    checks++; if (done_cnt - base_done !== 1) begin errors++; $display("[TB] FAIL done count: got %0d expected 1", done_cnt - base_done); end
    checks++; if (pulse_cnt - base_pulse !== 106) begin errors++; $display("[TB] FAIL pulse count: got %0d expected 106", pulse_cnt - base_pulse); end
    checks++; if (conv_seen_w !== 4'hF) begin errors++; $display("[TB] FAIL convert command seen: got %h expected f", conv_seen_w); end
    checks++; if (read_seen_w !== 4'hF) begin errors++; $display("[TB] FAIL read command seen: got %h expected f", read_seen_w); end
  endtask

  task automatic test_mixed_channels();
    bit seen;
    set_scratch(0, 64'h10_0C_FF_7F_46_4B_01_91, dallas_crc(64'h10_0C_FF_7F_46_4B_01_91));
    set_scratch(1, POR_DATA, 8'h1C);
    set_scratch(2, POR_DATA, 8'h1D);
    set_scratch(3, 64'h10_0C_FF_7F_46_4B_FF_5E, dallas_crc(64'h10_0C_FF_7F_46_4B_FF_5E));
    dev_present = 4'b1101;
    drive_start();
    wait_done(seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL mixed done: got none expected pulse within %0d clocks", CYCLE_LIMIT); end
    checks++; if (present !== 4'b1101) begin errors++; $display("[TB] FAIL mixed present: got %b expected 1101", present); end
    checks++; if (crc_ok !== 4'b1001) begin errors++; $display("[TB] FAIL mixed crc_ok: got %b expected 1001", crc_ok); end
    checks++; if (temp[15:0] !== 16'h0191) begin errors++; $display("[TB] FAIL mixed temp ch0: got %h expected 0191", temp[15:0]); end
    checks++; if (temp[31:16] !== 16'h0550) begin errors++; $display("[TB] FAIL mixed temp ch1: got %h expected 0550", temp[31:16]); end
    checks++; if (temp[47:32] !== 16'h0550) begin errors++; $display("[TB] FAIL mixed temp ch2: got %h expected 0550", temp[47:32]); end
    checks++; if (temp[63:48] !== 16'hFF5E) begin errors++; $display("[TB] FAIL mixed temp ch3: got %h expected ff5e", temp[63:48]); end
    repeat (20) @(negedge local_clk);
  endtask

  task automatic test_reset_mid_rx();
    int base_pulse, base_done, n;
    for (int k = 0; k < 4; k++) set_scratch(k, POR_DATA, 8'h1C);
    dev_present = 4'hF;
    base_pulse  = pulse_cnt;
    base_done   = done_cnt;
    drive_start();
    n = 0;
    while (pulse_cnt - base_pulse < 65 && n < CYCLE_LIMIT) begin
      @(negedge local_clk);
      n++;
    end
    checks++; if (pulse_cnt - base_pulse !== 65) begin errors++; $display("[TB] FAIL rx slot 30 reached: got %0d pulses expected 65", pulse_cnt - base_pulse); end
    mon_ignore = 1'b1;
    local_rst  = 1'b1;
    @(posedge local_clk);
    #1;
    checks++; if (bus_oe !== 4'h0) begin errors++; $display("[TB] FAIL mid reset bus_oe: got %h expected 0", bus_oe); end
    @(negedge local_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid reset busy: got %b expected 0", busy); end
    checks++; if (present !== 4'h0 || crc_ok !== 4'h0) begin errors++; $display("[TB] FAIL mid reset flags: got present %h crc_ok %h expected 0 0", present, crc_ok); end
    checks++; if (temp !== 64'h0) begin errors++; $display("[TB] FAIL mid reset temp: got %h expected 0", temp); end
    repeat (3) @(negedge local_clk);
    local_rst = 1'b0;
    repeat (1000) @(negedge local_clk);
    checks++; if (done_cnt !== base_done) begin errors++; $display("[TB] FAIL mid reset done pulses: got %0d expected 0", done_cnt - base_done); end
    checks++; if (pulse_cnt - base_pulse !== 65) begin errors++; $display("[TB] FAIL mid reset idle bus: got %0d pulses expected 65", pulse_cnt - base_pulse); end
  endtask

  task automatic test_restart_after_reset();
    bit seen;
    drive_start();
    wait_done(seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL restart done: got none expected pulse within %0d clocks", CYCLE_LIMIT); end
    checks++; if (present !== 4'hF || crc_ok !== 4'hF) begin errors++; $display("[TB] FAIL restart flags: got present %h crc_ok %h expected f f", present, crc_ok); end
    checks++; if (temp !== 64'h0550_0550_0550_0550) begin errors++; $display("[TB] FAIL restart temp: got %h expected 0550055005500550", temp); end
    repeat (20) @(negedge local_clk);
  endtask

  task automatic test_slot_timing();
    checks++;
    if (timing_bad !== 0) begin
      errors++;
      $display("[TB] FAIL slot timing: got %0d bad pulses (last %0t) expected 0", timing_bad, bad_width);
    end
  endtask

  initial begin
    test_reset();
    test_power_on_and_start();
    test_mixed_channels();
    test_reset_mid_rx();
    test_restart_after_reset();
    test_slot_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
